div_share_ctrl: RTL and testbench
=================================

DIV_SHARE_CTRL -- requirements
Module: div_share_ctrl

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 2, number of cycles the registered operands are held before the combinational divider result is sampled (range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1  requester i presents an operand pair.
REQ-005 SHALL have ports: req0_ready, req1_ready  output  1  controller accepts requester i this cycle.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  16  signed dividend (a) and divisor (b).
REQ-007 SHALL have ports: rsp_valid  output  1  and  rsp_ready  input  1  shared response handshake.
REQ-008 SHALL have ports: rsp_id  output  1  requester served; rsp_q, rsp_r  output  16  signed quotient and remainder; rsp_dz, rsp_ovf  output  1  divide-by-zero and overflow flags.

Function
REQ-009 SHALL implement FSM states IDLE, CALC, RESP; transitions IDLE->CALC on accept with b!=0 and not overflow, IDLE->RESP on accept with b==0 or overflow, CALC->RESP when settle counter reaches SETTLE_CYCLES-1, RESP->IDLE on rsp_valid&&rsp_ready.
REQ-010 SHALL assert reqN_ready only in IDLE, only for the granted requester, and never both in one cycle.
REQ-011 SHALL grant round-robin: sole valid requester wins; if both valid, the requester not served last wins; last-served pointer updates on each accept.
REQ-012 SHALL capture a, b and requester id into operand registers on the accepting edge; the divider sees only the registered operands.
REQ-013 SHALL count settle cycles from 0 in CALC and sample divider outputs into rsp_q/rsp_r on the CALC->RESP edge; rsp_valid rises SETTLE_CYCLES+1 edges after the accept edge.
REQ-014 SHALL produce a quotient truncated toward zero and a remainder carrying the dividend sign, with |r| < |b| and a == q*b + r (16-bit).
REQ-015 SHALL on b==0 skip CALC, set rsp_dz=1, rsp_q=16'h0000, rsp_r=a; rsp_valid rises 1 edge after accept.
REQ-016 SHALL on a==16'h8000 with b==16'hFFFF skip CALC, set rsp_ovf=1, rsp_q=16'h8000, rsp_r=16'h0000; rsp_valid rises 1 edge after accept.
REQ-017 SHALL hold rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf stable in RESP until rsp_ready is sampled high.
REQ-018 SHALL insert one IDLE cycle after each response handshake; no accept in the RESP->IDLE edge cycle.
REQ-019 SHALL ignore requester operand changes after accept; a requester withdrawing valid before ready is not served.
REQ-020 SHALL clear rsp_dz and rsp_ovf for normal results.

Reset
REQ-021 SHALL on rst_n==0 at a clock edge: state=IDLE, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_dz=0, rsp_ovf=0, settle counter=0, last-served pointer=1 (requester 0 wins first tie).
REQ-022 SHALL abort any in-flight division on reset with no response issued; reset has priority over every transition.
REQ-023 SHALL drive req0_ready=req1_ready=0 in any cycle where rst_n is low.

Structure
REQ-024 SHALL place the FSM state enum, SETTLE_CYCLES default, and constants 16'h8000/16'hFFFF (overflow pair) in shared package div_ctrl_pkg.
REQ-025 SHALL instantiate exactly one sub-module, the existing combinational signed divider Divider16bit (ports A, B, Qf, R), fed from the operand registers.

Verification
REQ-026 SHALL cover: req0 a=007E b=0003, rsp_ready=1 -> rsp_valid 3 edges after accept, id=0, q=002A, r=0000, dz=0, ovf=0.
REQ-027 SHALL cover: req0 and req1 valid together after reset, req0 a=FF82 b=0004, req1 a=7FFF b=03E8 -> req0 served first (q=FFE1 r=FFFE), then req1 (q=0020 r=02FF); third tie goes to req0.
REQ-028 SHALL cover: req1 a=8001 b=FC18 with rsp_ready low 5 cycles -> rsp_valid and q=0020 r=FD01 held stable until rsp_ready high, then one IDLE cycle.
REQ-029 SHALL cover: a=0079 b=0000 -> rsp_dz=1, q=0000, r=0079, rsp_valid 1 edge after accept; a=8000 b=FFFF -> rsp_ovf=1, q=8000, r=0000.
REQ-030 SHALL cover: rst_n low during CALC of a=007E b=0020 -> no rsp_valid, all outputs zero, next accept proceeds normally with req0 winning tie.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the shared-divider controller: FSM state
// encoding, default settle time and the signed overflow operand pair.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } ctrlState_t;

  localparam int SETTLE_CYCLES_DEFAULT = 2;

  // The only signed 16-bit division whose quotient does not fit: -32768 / -1
  localparam logic [15:0] OVF_DIVIDEND = 16'h8000;
  localparam logic [15:0] OVF_DIVISOR  = 16'hFFFF;

  function automatic logic isOverflowPair(input logic [15:0] a, input logic [15:0] b);
    return (a == OVF_DIVIDEND) && (b == OVF_DIVISOR);
  endfunction

endpackage

// File: rtl/div_share_ctrl_divider.sv
// Combinational signed 16-bit divider. Quotient truncates toward zero and
// the remainder takes the sign of the dividend. Works on magnitudes with a
// fully unrolled restoring division so every input (including B == 0)
// yields a defined value; the controller overrides the B == 0 and
// overflow cases, so their raw outputs are never used.
module Divider16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Qf,
  output logic [15:0] R
);

  logic [15:0] w_magA;
  logic [15:0] w_magB;
  logic [15:0] w_magQ;
  logic [15:0] w_rem;
  logic [16:0] w_shift;

  // Unsigned restoring division on operand magnitudes, one quotient bit per step
  always_comb begin
    w_magA  = A[15] ? (~A + 16'd1) : A;
    w_magB  = B[15] ? (~B + 16'd1) : B;
    w_magQ  = '0;
    w_rem   = '0;
    w_shift = '0;
    for (int i = 15; i >= 0; i--) begin
      w_shift = {w_rem, w_magA[i]};
      if (w_shift >= {1'b0, w_magB}) begin
        w_shift   = w_shift - {1'b0, w_magB};
        w_magQ[i] = 1'b1;
      end
      w_rem = w_shift[15:0];
    end
  end

  // Restore signs: quotient negative when operand signs differ, remainder follows dividend
  always_comb begin
    Qf = (A[15] ^ B[15]) ? (~w_magQ + 16'd1) : w_magQ;
    R  = A[15] ? (~w_rem + 16'd1) : w_rem;
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Two-requester front end for one shared combinational divider.
// A round-robin arbiter accepts one operand pair at a time, registers it,
// lets the divider settle for SETTLE_CYCLES cycles, then holds the result
// on the response port until it is taken. Divide-by-zero and the
// -32768 / -1 overflow are answered directly without waiting on the divider.
module div_share_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_q,
  output logic [15:0] rsp_r,
  output logic        rsp_dz,
  output logic        rsp_ovf
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  ctrlState_t  r_state;
  ctrlState_t  w_nextState;

  logic [3:0]  r_settleCnt;
  logic        r_lastServed;
  logic [15:0] r_opA;
  logic [15:0] r_opB;
  logic        r_opId;

  logic        r_rspId;
  logic [15:0] r_rspQ;
  logic [15:0] r_rspR;
  logic        r_rspDz;
  logic        r_rspOvf;

  logic        w_inIdle;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_selId;
  logic [15:0] w_selA;
  logic [15:0] w_selB;
  logic        w_selDz;
  logic        w_selOvf;
  logic        w_selSpecial;
  logic        w_settleDone;
  logic [15:0] w_divQ;
  logic [15:0] w_divR;

  // Arbitration: a lone requester always wins; on a tie the one not served last wins.
  // Ready is only offered in IDLE and never while reset is asserted.
  assign w_inIdle   = (r_state == IDLE) && rst_n;
  assign w_grant0   = req0_valid && (!req1_valid || r_lastServed);
  assign w_grant1   = req1_valid && (!req0_valid || !r_lastServed);
  assign req0_ready = w_inIdle && w_grant0;
  assign req1_ready = w_inIdle && w_grant1;

  // Selected request and its classification as a short-circuit case
  assign w_accept     = req0_ready || req1_ready;
  assign w_selId      = req1_ready;
  assign w_selA       = w_selId ? req1_a : req0_a;
  assign w_selB       = w_selId ? req1_b : req0_b;
  assign w_selDz      = (w_selB == 16'h0000);
  assign w_selOvf     = isOverflowPair(w_selA, w_selB);
  assign w_selSpecial = w_selDz || w_selOvf;

  assign w_settleDone = (r_settleCnt == SETTLE_LAST);

  // The divider only ever sees the registered operands, never live requester inputs
  Divider16bit u_divider (
    .A  (r_opA),
    .B  (r_opB),
    .Qf (w_divQ),
    .R  (w_divR)
  );

  // State register; reset wins over any pending transition and drops an in-flight division
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = w_selSpecial ? RESP : CALC;
        end
      end
      CALC: begin
        if (w_settleDone) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand capture on accept, settle counting, and loading of the held response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_settleCnt  <= '0;
      r_lastServed <= 1'b1;
      r_opA        <= '0;
      r_opB        <= '0;
      r_opId       <= 1'b0;
      r_rspId      <= 1'b0;
      r_rspQ       <= '0;
      r_rspR       <= '0;
      r_rspDz      <= 1'b0;
      r_rspOvf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opA        <= w_selA;
        r_opB        <= w_selB;
        r_opId       <= w_selId;
        r_lastServed <= w_selId;
      end
      case (r_state)
        IDLE: begin
          r_settleCnt <= '0;
          if (w_accept && w_selSpecial) begin
            r_rspId  <= w_selId;
            r_rspDz  <= w_selDz;
            r_rspOvf <= w_selOvf;
            r_rspQ   <= w_selDz ? 16'h0000 : OVF_DIVIDEND;
            r_rspR   <= w_selDz ? w_selA : 16'h0000;
          end
        end
        CALC: begin
          if (w_settleDone) begin
            r_settleCnt <= '0;
            r_rspId     <= r_opId;
            r_rspQ      <= w_divQ;
            r_rspR      <= w_divR;
            r_rspDz     <= 1'b0;
            r_rspOvf    <= 1'b0;
          end else begin
            r_settleCnt <= r_settleCnt + 4'd1;
          end
        end
        default: begin
          r_settleCnt <= '0;
        end
      endcase
    end
  end

  // Response port is a direct view of the held registers
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rspId;
  assign rsp_q     = r_rspQ;
  assign rsp_r     = r_rspR;
  assign rsp_dz    = r_rspDz;
  assign rsp_ovf   = r_rspOvf;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: arbitration, settle latency,
// divide-by-zero / overflow short cuts, back-pressure and reset abort.
module tb_div_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_q;
  logic [15:0] rsp_r;
  logic        rsp_dz;
  logic        rsp_ovf;

  int checks;
  int errors;
  int edges;

  div_share_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_q      (rsp_q),
    .rsp_r      (rsp_r),
    .rsp_dz     (rsp_dz),
    .rsp_ovf    (rsp_ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both requesters, then let combinational outputs settle
  task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                               input logic v1, input logic [15:0] a1, input logic [15:0] b1);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    #1;
  endtask

  // One comparison point
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Count edges from the accept edge (edge 1) until rsp_valid shows, bounded
  task automatic waitRsp(output int count);
    count = 1;
    while (!rsp_valid && count < 40) begin
      @(negedge clk);
      count++;
    end
  endtask

  task automatic checkRsp(input string tag, input logic id, input logic [15:0] q,
                          input logic [15:0] r, input logic dz, input logic ovf);
    checkOutput({tag, "_valid"}, rsp_valid, 1'b1);
    checkOutput({tag, "_id"},    rsp_id,    id);
    checkOutput({tag, "_q"},     rsp_q,     q);
    checkOutput({tag, "_r"},     rsp_r,     r);
    checkOutput({tag, "_dz"},    rsp_dz,    dz);
    checkOutput({tag, "_ovf"},   rsp_ovf,   ovf);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 16'h1234, 16'h0001, 1'b1, 16'h5678, 16'h0002);
    @(negedge clk);
    @(negedge clk);

    // Reset state: no ready while in reset, response port cleared
    checkOutput("rst_req0_ready", req0_ready, 1'b0);
    checkOutput("rst_req1_ready", req1_ready, 1'b0);
    checkOutput("rst_rsp_valid",  rsp_valid,  1'b0);
    checkOutput("rst_rsp_q",      rsp_q,      16'h0000);
    checkOutput("rst_rsp_r",      rsp_r,      16'h0000);
    checkOutput("rst_rsp_dz",     rsp_dz,     1'b0);
    checkOutput("rst_rsp_ovf",    rsp_ovf,    1'b0);
    checkOutput("rst_rsp_id",     rsp_id,     1'b0);

    // 126 / 3 from requester 0 with the response taken immediately
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 16'h007E, 16'h0003, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t1_req0_ready", req0_ready, 1'b1);
    checkOutput("t1_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    waitRsp(edges);
    checkOutput("t1_latency", 16'(edges), 16'd3);
    checkRsp("t1", 1'b0, 16'h002A, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_done_valid", rsp_valid, 1'b0);

    // Tie straight after reset: requester 0 first, then requester 1, third tie back to 0
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'hFF82, 16'h0004, 1'b1, 16'h7FFF, 16'h03E8);
    checkOutput("t2_tie_req0_ready", req0_ready, 1'b1);
    checkOutput("t2_tie_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h1111, 16'h2222, 1'b1, 16'h7FFF, 16'h03E8);
    waitRsp(edges);
    checkOutput("t2a_latency", 16'(edges), 16'd3);
    checkRsp("t2a", 1'b0, 16'hFFE1, 16'hFFFE, 1'b0, 1'b0);
    checkOutput("t2a_req1_ready_in_resp", req1_ready, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t2a_done_valid", rsp_valid, 1'b0);
    checkOutput("t2b_req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    waitRsp(edges);
    checkOutput("t2b_latency", 16'(edges), 16'd3);
    checkRsp("t2b", 1'b1, 16'h0020, 16'h02FF, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2b_done_valid", rsp_valid, 1'b0);
    applyStimulus(1'b1, 16'h0055, 16'h0000, 1'b1, 16'h0066, 16'h0000);
    checkOutput("t2c_tie_req0_ready", req0_ready, 1'b1);
    checkOutput("t2c_tie_req1_ready", req1_ready, 1'b0);
    // Both withdraw before the edge, so nothing is served
    applyStimulus(1'b0, 16'h0055, 16'h0000, 1'b0, 16'h0066, 16'h0000);
    @(negedge clk);
    checkOutput("t2c_withdrawn_valid", rsp_valid, 1'b0);

    // Requester 1 with back-pressure; later operand changes must not leak in
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h8001, 16'hFC18);
    checkOutput("t3_req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1234, 16'h5678);
    waitRsp(edges);
    checkOutput("t3_latency", 16'(edges), 16'd3);
    for (int i = 0; i < 5; i++) begin
      checkRsp("t3_hold", 1'b1, 16'h0020, 16'hFD01, 1'b0, 1'b0);
      @(negedge clk);
    end
    checkRsp("t3_hold_end", 1'b1, 16'h0020, 16'hFD01, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 16'h0079, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t3_no_accept_in_resp", req0_ready, 1'b0);
    @(negedge clk);
    checkOutput("t3_done_valid", rsp_valid, 1'b0);
    checkOutput("t4_req0_ready", req0_ready, 1'b1);

    // Divide by zero: answered one edge after accept
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    waitRsp(edges);
    checkOutput("t4_dz_latency", 16'(edges), 16'd1);
    checkRsp("t4_dz", 1'b0, 16'h0000, 16'h0079, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t4_dz_done_valid", rsp_valid, 1'b0);

    // -32768 / -1 overflow
    applyStimulus(1'b1, 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t4_ovf_req0_ready", req0_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    waitRsp(edges);
    checkOutput("t4_ovf_latency", 16'(edges), 16'd1);
    checkRsp("t4_ovf", 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);

    // Normal result after the flagged ones: 100 / -7 = -14 rem 2, flags cleared
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0064, 16'hFFF9);
    checkOutput("t4_norm_req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    waitRsp(edges);
    checkOutput("t4_norm_latency", 16'(edges), 16'd3);
    checkRsp("t4_norm", 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);

    // Reset during CALC aborts the division; afterwards requester 0 wins the tie again
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 16'h007E, 16'h0020, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t5_req0_ready", req0_ready, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'h007E, 16'h0020, 1'b1, 16'h0005, 16'h0001);
    checkOutput("t5_rst_req0_ready", req0_ready, 1'b0);
    checkOutput("t5_rst_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    checkOutput("t5_rst_valid", rsp_valid, 1'b0);
    checkOutput("t5_rst_id",    rsp_id,    1'b0);
    checkOutput("t5_rst_q",     rsp_q,     16'h0000);
    checkOutput("t5_rst_r",     rsp_r,     16'h0000);
    checkOutput("t5_rst_dz",    rsp_dz,    1'b0);
    checkOutput("t5_rst_ovf",   rsp_ovf,   1'b0);
    @(negedge clk);
    checkOutput("t5_rst_valid_late", rsp_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("t5_tie_req0_ready", req0_ready, 1'b1);
    checkOutput("t5_tie_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    waitRsp(edges);
    checkOutput("t5_latency", 16'(edges), 16'd3);
    checkRsp("t5", 1'b0, 16'h0003, 16'h001E, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_done_valid", rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
